pc_redirect_unit: RTL and testbench

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_target_calc.sv | 33 +++
 rtl/pc_redirect_unit.sv | 105 ++++++++++
 tb/tb_pc_redirect_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared redirect codes, slot-FSM state encoding and decode helpers
// for the fetch-PC redirect logic.
package pc_pkg;

  typedef enum logic [2:0] {
    sel_seq  = 3'd0,
    sel_br   = 3'd1,
    sel_j    = 3'd2,
    sel_jr   = 3'd3,
    sel_exc  = 3'd4,
    sel_eret = 3'd5
  } sel_e;

  typedef enum logic {
    st_idle = 1'b0,
    st_slot = 1'b1
  } slot_state_e;

  // Codes 6 and 7 are unassigned and fall through to sequential fetch.
  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel == sel_br) || (sel == sel_j) || (sel == sel_jr);
  endfunction

  function automatic logic is_exc(input logic [2:0] sel);
    return sel == sel_exc;
  endfunction

  function automatic logic is_eret(input logic [2:0] sel);
    return sel == sel_eret;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch, jump and register-jump target generation
// from the sequential address and the instruction fields.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int AW    = 32,
  parameter int IDX_W = 26
) (
  input  logic [AW-1:0]    pc_plus4,
  input  logic [IDX_W-1:0] jidx,
  input  logic [15:0]      boff,
  input  logic [AW-3:0]    rs_word,
  output logic [AW-1:0]    br_target,
  output logic [AW-1:0]    jtarget,
  output logic [AW-1:0]    jr_target
);

  logic [AW-1:0] boff_ext;

  assign boff_ext  = AW'($signed(boff));
  // Word offset scaled to bytes; the sum wraps naturally modulo 2^AW.
  assign br_target = pc_plus4 + (boff_ext << 2);
  assign jr_target = {rs_word, 2'b00};

  generate
    if (AW > IDX_W + 2) begin : g_region
      assign jtarget = {pc_plus4[AW-1:IDX_W+2], jidx, 2'b00};
    end else begin : g_noregion
      assign jtarget = {jidx, 2'b00};
    end
  endgenerate

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with priority redirect selection and an optional
// single-instruction delay slot for BR/J/JR.
//
// state   | meaning
// --------+--------------------------------------------------------
// st_idle | normal fetch; BR/J/JR either redirect or open a slot
// st_slot | delay-slot instruction fetched; target latched in tgt_q
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int            AW         = 32,
  parameter int            IDX_W      = 26,
  parameter int            DELAY_SLOT = 0,
  parameter logic [AW-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [AW-1:0] EXC_VEC    = 32'h0040_0004
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic [IDX_W-1:0] jidx,
  input  logic [15:0]      boff,
  input  logic [AW-1:0]    rs_val,
  input  logic [AW-1:0]    epc,
  output logic [AW-1:0]    pc,
  output logic [AW-1:0]    pc_plus4,
  output logic [AW-1:0]    jtarget,
  output logic             slot_pending,
  output logic             addr_err
);

  slot_state_e   state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [AW-1:0] br_target, jr_target, redir_target;

  assign pc_plus4 = pc_q + AW'(4);
  assign pc       = pc_q;

  pc_target_calc #(
    .AW    (AW),
    .IDX_W (IDX_W)
  ) u_calc (
    .pc_plus4  (pc_plus4),
    .jidx      (jidx),
    .boff      (boff),
    .rs_word   (rs_val[AW-1:2]),
    .br_target (br_target),
    .jtarget   (jtarget),
    .jr_target (jr_target)
  );

  always_comb begin
    case (sel)
      sel_br:  redir_target = br_target;
      sel_j:   redir_target = jtarget;
      sel_jr:  redir_target = jr_target;
      default: redir_target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= st_idle;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // EXC and ERET win over stall so a stalled pipe can still take a trap.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (is_exc(sel)) begin
      pc_d    = EXC_VEC;
      state_d = st_idle;
      tgt_d   = '0;
    end else if (is_eret(sel)) begin
      pc_d    = epc;
      state_d = st_idle;
    end else if (!stall) begin
      if (state_q == st_slot) begin
        pc_d    = tgt_q;
        state_d = st_idle;
      end else if ((DELAY_SLOT != 0) && is_redirect(sel)) begin
        pc_d    = pc_plus4;
        tgt_d   = redir_target;
        state_d = st_slot;
      end else begin
        pc_d = redir_target;
      end
    end
  end

  always_comb begin
    slot_pending = (state_q == st_slot);
    addr_err     = (sel == sel_jr) && (rs_val[1:0] != 2'b00);
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench: immediate-delay and delay-slot instances driven
// with shared stimulus, each compared against its own reference model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [25:0] jidx = '0;
  logic [15:0] boff = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] epc = '0;

  logic [31:0] pc0, pc_plus4_0, jtarget0;
  logic        slot0, addr_err0;
  logic [31:0] pc1, pc_plus4_1, jtarget1;
  logic        slot1, addr_err1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc0, m_pc1, m_tgt1;
  logic        m_pend1;

  always #5 clk = ~clk;

  pc_redirect_unit #(.DELAY_SLOT(0)) u_dut0 (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel), .jidx(jidx), .boff(boff),
    .rs_val(rs_val), .epc(epc), .pc(pc0), .pc_plus4(pc_plus4_0),
    .jtarget(jtarget0), .slot_pending(slot0), .addr_err(addr_err0)
  );

  pc_redirect_unit #(.DELAY_SLOT(1)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel), .jidx(jidx), .boff(boff),
    .rs_val(rs_val), .epc(epc), .pc(pc1), .pc_plus4(pc_plus4_1),
    .jtarget(jtarget1), .slot_pending(slot1), .addr_err(addr_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] jump_of(input logic [31:0] p);
    return ((p + 32'd4) & 32'hF000_0000) | ({6'b0, jidx} * 32'd4);
  endfunction

  // Target the given PC would be sent to by the current sel (SEQ -> p+4).
  function automatic logic [31:0] target_of(input logic [31:0] p);
    int signed off;
    off = $signed(boff);
    case (sel)
      3'd1: return (p + 32'd4) + 32'(off * 4);
      3'd2: return jump_of(p);
      3'd3: return rs_val & 32'hFFFF_FFFC;
      default: return p + 32'd4;
    endcase
  endfunction

  function automatic bit is_branchy();
    return sel == 3'd1 || sel == 3'd2 || sel == 3'd3;
  endfunction

  task automatic model_reset();
    m_pc0 = RST_PC; m_pc1 = RST_PC; m_tgt1 = '0; m_pend1 = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] t0, t1;
    t0 = target_of(m_pc0);
    t1 = target_of(m_pc1);
    if (sel == 3'd4) begin
      m_pc0 = EXC_PC; m_pc1 = EXC_PC; m_pend1 = 1'b0; m_tgt1 = '0;
    end else if (sel == 3'd5) begin
      m_pc0 = epc; m_pc1 = epc; m_pend1 = 1'b0;
    end else if (!stall) begin
      m_pc0 = t0;
      if (m_pend1) begin
        m_pc1 = m_tgt1; m_pend1 = 1'b0;
      end else if (is_branchy()) begin
        m_tgt1 = t1; m_pc1 = m_pc1 + 32'd4; m_pend1 = 1'b1;
      end else begin
        m_pc1 = t1;
      end
    end
  endtask

  task automatic step(input logic [2:0] s, input logic st);
    sel = s;
    stall = st;
    #1;
    chk("d0 pc_plus4", pc_plus4_0, m_pc0 + 32'd4);
    chk("d1 pc_plus4", pc_plus4_1, m_pc1 + 32'd4);
    chk("d0 jtarget", jtarget0, jump_of(m_pc0));
    chk("d1 jtarget", jtarget1, jump_of(m_pc1));
    chk("d0 addr_err", 32'(addr_err0), 32'(sel == 3'd3 && rs_val[1:0] != 2'b00));
    chk("d1 addr_err", 32'(addr_err1), 32'(sel == 3'd3 && rs_val[1:0] != 2'b00));
    @(posedge clk);
    model_edge();
    #1;
    chk("d0 pc", pc0, m_pc0);
    chk("d1 pc", pc1, m_pc1);
    chk("d0 slot_pending", 32'(slot0), 32'd0);
    chk("d1 slot_pending", 32'(slot1), 32'(m_pend1));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc d0", pc0, RST_PC);
    chk("reset pc d1", pc1, RST_PC);
    chk("reset slot d1", 32'(slot1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post-release pc", pc0, RST_PC);

    step(3'd0, 1'b0); chk("seq1", pc0, 32'h0040_0004);
    step(3'd0, 1'b0); chk("seq2", pc0, 32'h0040_0008);
    step(3'd0, 1'b0); chk("seq3", pc1, 32'h0040_000C);
    step(3'd6, 1'b0); chk("seq code6", pc0, 32'h0040_0010);

    jidx = 26'h0100020;
    step(3'd2, 1'b0);
    chk("j immediate", pc0, 32'h0040_0080);
    chk("j slot pc", pc1, 32'h0040_0014);
    step(3'd0, 1'b0);
    chk("j slot release", pc1, 32'h0040_0080);

    epc = 32'h0040_0020;
    step(3'd5, 1'b0);
    boff = 16'hFFFE;
    step(3'd1, 1'b0);
    chk("br immediate", pc0, 32'h0040_001C);
    chk("br slot pc", pc1, 32'h0040_0024);
    chk("br slot pend", 32'(slot1), 32'd1);
    step(3'd1, 1'b0);
    chk("br release", pc1, 32'h0040_001C);
    chk("br release pend", 32'(slot1), 32'd0);

    step(3'd1, 1'b0);
    step(3'd2, 1'b1);
    step(3'd0, 1'b1);
    chk("stall hold pc", pc1, 32'h0040_0020);
    chk("stall hold pend", 32'(slot1), 32'd1);
    step(3'd0, 1'b0);
    chk("stall release", pc1, 32'h0040_0018);

    step(3'd2, 1'b0);
    step(3'd4, 1'b1);
    chk("exc pc", pc1, 32'h0040_0004);
    chk("exc pend", 32'(slot1), 32'd0);
    epc = 32'h0040_0100;
    step(3'd5, 1'b1);
    chk("eret pc", pc1, 32'h0040_0100);

    rs_val = 32'h0040_0103;
    sel = 3'd3;
    #1;
    chk("jr addr_err", 32'(addr_err0), 32'd1);
    step(3'd3, 1'b0);
    chk("jr target", pc0, 32'h0040_0100);
    chk("jr slot", 32'(slot1), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async rst d0", pc0, RST_PC);
    chk("async rst d1", pc1, RST_PC);
    chk("async rst pend", 32'(slot1), 32'd0);
    sel = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst release hold", pc1, RST_PC);
    step(3'd0, 1'b0);
    chk("first post-rst", pc1, 32'h0040_0004);

    epc = 32'hFFFF_FFF8;
    step(3'd5, 1'b0);
    step(3'd0, 1'b0);
    step(3'd0, 1'b0);
    chk("wrap", pc0, 32'h0000_0000);

    for (int i = 0; i < 400; i++) begin
      jidx   = 26'($urandom);
      boff   = 16'($urandom);
      rs_val = $urandom;
      epc    = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFF4;
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
